// File: rtl/hpdmc_ddr16_wrdata_sched.sv
// DDR16 write-data scheduler: splits 32-bit words into D0/D1 halves and drives the DQS pre/data/post pattern.
// Registered outputs lag state by one cycle; DATA never stalls, so a missing wvalid becomes a masked underrun beat.
module hpdmc_ddr16_wrdata_sched #(
    parameter int BURST_WORDS = 4,
    parameter int WR_LATENCY  = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wr_start,
    output logic        busy,
    output logic        start_err,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wvalid,
    output logic        wready,
    output logic [15:0] dq_d0,
    output logic [15:0] dq_d1,
    output logic [1:0]  dm_d0,
    output logic [1:0]  dm_d1,
    output logic        dq_oe,
    output logic        dqs_d0,
    output logic        dqs_d1,
    output logic        dqs_oe,
    output logic        underrun
);

    localparam int BW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_WORDS - 1);
    localparam logic [2:0]    LAT_INIT  = 3'((WR_LATENCY > 0) ? WR_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAT,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    typedef struct packed {
        logic [15:0] dq_d0;
        logic [15:0] dq_d1;
        logic [1:0]  dm_d0;
        logic [1:0]  dm_d1;
        logic        dq_oe;
        logic        dqs_d0;
        logic        dqs_d1;
        logic        dqs_oe;
        logic        underrun;
        logic        start_err;
    } pin_t;

    state_t        state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic [BW-1:0] beat_q, beat_d;
    pin_t          pin_q, pin_d;

    always_comb begin
        state_d         = state_q;
        lat_d           = lat_q;
        beat_d          = beat_q;
        pin_d           = '0;
        pin_d.start_err = wr_start && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (wr_start) begin
                    if (WR_LATENCY == 0) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_LAT;
                        lat_d   = LAT_INIT;
                    end
                end
            end
            S_LAT: begin
                if (lat_q == 3'd0) begin
                    state_d = S_PRE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_PRE: begin
                pin_d.dqs_oe = 1'b1;
                state_d      = S_DATA;
                beat_d       = '0;
            end
            S_DATA: begin
                pin_d.dq_oe  = 1'b1;
                pin_d.dqs_oe = 1'b1;
                pin_d.dqs_d0 = 1'b1;
                if (wvalid) begin
                    pin_d.dq_d0 = wdata[31:16];
                    pin_d.dq_d1 = wdata[15:0];
                    pin_d.dm_d0 = ~wmask[3:2];
                    pin_d.dm_d1 = ~wmask[1:0];
                end else begin
                    // The beat slot is fixed by DRAM timing: mask it rather than slip the burst.
                    pin_d.dm_d0    = 2'b11;
                    pin_d.dm_d1    = 2'b11;
                    pin_d.underrun = 1'b1;
                end
                if (beat_q == BEAT_LAST) begin
                    state_d = S_POST;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_POST: begin
                pin_d.dqs_oe = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            pin_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            pin_q   <= pin_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign wready    = (state_q == S_DATA);
    assign start_err = pin_q.start_err;
    assign dq_d0     = pin_q.dq_d0;
    assign dq_d1     = pin_q.dq_d1;
    assign dm_d0     = pin_q.dm_d0;
    assign dm_d1     = pin_q.dm_d1;
    assign dq_oe     = pin_q.dq_oe;
    assign dqs_d0    = pin_q.dqs_d0;
    assign dqs_d1    = pin_q.dqs_d1;
    assign dqs_oe    = pin_q.dqs_oe;
    assign underrun  = pin_q.underrun;

endmodule

// File: tb/tb_hpdmc_ddr16_wrdata_sched.sv
// Directed bench: per-cycle vector table for the main instance, plus latency and async-reset sequences.
module tb_hpdmc_ddr16_wrdata_sched;

    localparam int Q  = 0;
    localparam int PR = 1;
    localparam int BT = 2;
    localparam int PO = 3;
    localparam int NROWS = 28;

    typedef struct {
        logic        st;
        logic        vld;
        logic [31:0] d;
        logic [3:0]  m;
        logic [43:0] exp;
    } vec_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        wr_start [3];
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;

    logic        busy [3];
    logic        start_err [3];
    logic        wready [3];
    logic [15:0] dq_d0 [3];
    logic [15:0] dq_d1 [3];
    logic [1:0]  dm_d0 [3];
    logic [1:0]  dm_d1 [3];
    logic        dq_oe [3];
    logic        dqs_d0 [3];
    logic        dqs_d1 [3];
    logic        dqs_oe [3];
    logic        underrun [3];

    logic [43:0] act;
    vec_t        tbl [NROWS];
    int          checks = 0;
    int          errors = 0;

    hpdmc_ddr16_wrdata_sched #(.BURST_WORDS(4), .WR_LATENCY(1)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_start(wr_start[0]),
        .busy(busy[0]), .start_err(start_err[0]),
        .wdata(wdata), .wmask(wmask), .wvalid(wvalid), .wready(wready[0]),
        .dq_d0(dq_d0[0]), .dq_d1(dq_d1[0]), .dm_d0(dm_d0[0]), .dm_d1(dm_d1[0]),
        .dq_oe(dq_oe[0]), .dqs_d0(dqs_d0[0]), .dqs_d1(dqs_d1[0]), .dqs_oe(dqs_oe[0]),
        .underrun(underrun[0])
    );

    hpdmc_ddr16_wrdata_sched #(.BURST_WORDS(4), .WR_LATENCY(0)) u_dut_l0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_start(wr_start[1]),
        .busy(busy[1]), .start_err(start_err[1]),
        .wdata(wdata), .wmask(wmask), .wvalid(wvalid), .wready(wready[1]),
        .dq_d0(dq_d0[1]), .dq_d1(dq_d1[1]), .dm_d0(dm_d0[1]), .dm_d1(dm_d1[1]),
        .dq_oe(dq_oe[1]), .dqs_d0(dqs_d0[1]), .dqs_d1(dqs_d1[1]), .dqs_oe(dqs_oe[1]),
        .underrun(underrun[1])
    );

    hpdmc_ddr16_wrdata_sched #(.BURST_WORDS(4), .WR_LATENCY(7)) u_dut_l7 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_start(wr_start[2]),
        .busy(busy[2]), .start_err(start_err[2]),
        .wdata(wdata), .wmask(wmask), .wvalid(wvalid), .wready(wready[2]),
        .dq_d0(dq_d0[2]), .dq_d1(dq_d1[2]), .dm_d0(dm_d0[2]), .dm_d1(dm_d1[2]),
        .dq_oe(dq_oe[2]), .dqs_d0(dqs_d0[2]), .dqs_d1(dqs_d1[2]), .dqs_oe(dqs_oe[2]),
        .underrun(underrun[2])
    );

    assign act = {busy[0], wready[0], start_err[0], underrun[0],
                  dq_oe[0], dqs_oe[0], dqs_d0[0], dqs_d1[0],
                  dm_d0[0], dm_d1[0], dq_d0[0], dq_d1[0]};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic vec_t mk(input logic st, input logic vld, input logic [31:0] d,
                                input logic [3:0] m, input logic bsy, input logic rdy,
                                input logic serr, input logic ur, input int ph,
                                input logic [1:0] dm0, input logic [1:0] dm1,
                                input logic [15:0] q0, input logic [15:0] q1);
        vec_t       v;
        logic [3:0] strb;
        case (ph)
            PR:      strb = 4'b0100;
            BT:      strb = 4'b1110;
            PO:      strb = 4'b0100;
            default: strb = 4'b0000;
        endcase
        v.st  = st;
        v.vld = vld;
        v.d   = d;
        v.m   = m;
        v.exp = {bsy, rdy, serr, ur, strb, dm0, dm1, q0, q1};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input int i);
        wr_start[0] = tbl[i].st;
        wvalid      = tbl[i].vld;
        wdata       = tbl[i].d;
        wmask       = tbl[i].m;
    endtask

    task automatic run_row(input int i);
        drive(i);
        @(negedge sys_clk);
        chk($sformatf("row%0d", i), {20'b0, act}, {20'b0, tbl[i].exp});
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        // Burst A: plain 4-word burst with all bytes enabled.
        tbl[0]  = mk(1, 0, 32'h0, 4'h0, 0, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[1]  = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[2]  = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[3]  = mk(0, 1, 32'h11112222, 4'hF, 1, 1, 0, 0, PR, 2'b00, 2'b00, 16'h0, 16'h0);
        tbl[4]  = mk(0, 1, 32'h33334444, 4'hF, 1, 1, 0, 0, BT, 2'b00, 2'b00, 16'h1111, 16'h2222);
        tbl[5]  = mk(0, 1, 32'h55556666, 4'hF, 1, 1, 0, 0, BT, 2'b00, 2'b00, 16'h3333, 16'h4444);
        tbl[6]  = mk(0, 1, 32'h77778888, 4'hF, 1, 1, 0, 0, BT, 2'b00, 2'b00, 16'h5555, 16'h6666);
        tbl[7]  = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, BT, 2'b00, 2'b00, 16'h7777, 16'h8888);
        tbl[8]  = mk(0, 0, 32'h0, 4'h0, 0, 0, 0, 0, PO, 2'b00, 2'b00, 16'h0, 16'h0);
        tbl[9]  = mk(0, 0, 32'h0, 4'h0, 0, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        // Burst B: partial mask, start while busy, underrun at beat 2, restart at relative cycle 8.
        tbl[10] = mk(1, 0, 32'h0, 4'h0, 0, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[11] = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[12] = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[13] = mk(0, 1, 32'hAAAABBBB, 4'b1001, 1, 1, 0, 0, PR, 2'b00, 2'b00, 16'h0, 16'h0);
        tbl[14] = mk(1, 1, 32'h12345678, 4'hF, 1, 1, 0, 0, BT, 2'b01, 2'b10, 16'hAAAA, 16'hBBBB);
        tbl[15] = mk(0, 0, 32'h0, 4'h0, 1, 1, 1, 0, BT, 2'b00, 2'b00, 16'h1234, 16'h5678);
        tbl[16] = mk(0, 1, 32'h9ABCDEF0, 4'hF, 1, 1, 0, 1, BT, 2'b11, 2'b11, 16'h0, 16'h0);
        tbl[17] = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, BT, 2'b00, 2'b00, 16'h9ABC, 16'hDEF0);
        tbl[18] = mk(1, 0, 32'h0, 4'h0, 0, 0, 0, 0, PO, 2'b00, 2'b00, 16'h0, 16'h0);
        tbl[19] = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[20] = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);
        tbl[21] = mk(0, 1, 32'hCAFEF00D, 4'b0110, 1, 1, 0, 0, PR, 2'b00, 2'b00, 16'h0, 16'h0);
        tbl[22] = mk(0, 1, 32'h01020304, 4'hF, 1, 1, 0, 0, BT, 2'b10, 2'b01, 16'hCAFE, 16'hF00D);
        tbl[23] = mk(0, 1, 32'h05060708, 4'hF, 1, 1, 0, 0, BT, 2'b00, 2'b00, 16'h0102, 16'h0304);
        tbl[24] = mk(0, 1, 32'h090A0B0C, 4'hF, 1, 1, 0, 0, BT, 2'b00, 2'b00, 16'h0506, 16'h0708);
        tbl[25] = mk(0, 0, 32'h0, 4'h0, 1, 0, 0, 0, BT, 2'b00, 2'b00, 16'h090A, 16'h0B0C);
        tbl[26] = mk(0, 0, 32'h0, 4'h0, 0, 0, 0, 0, PO, 2'b00, 2'b00, 16'h0, 16'h0);
        tbl[27] = mk(0, 0, 32'h0, 4'h0, 0, 0, 0, 0, Q,  2'b00, 2'b00, 16'h0, 16'h0);

        sys_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) wr_start[k] = 1'b0;
        wvalid = 1'b0;
        wdata  = 32'h0;
        wmask  = 4'h0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_state", {20'b0, act}, 64'h0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        for (int i = 0; i < NROWS; i++) run_row(i);

        // Latency extremes: WR_LATENCY=0 puts PRE at cycle 1, WR_LATENCY=7 at cycle 8.
        wvalid = 1'b1;
        wdata  = 32'h0F0F0F0F;
        wmask  = 4'hF;
        for (int c = 0; c < 15; c++) begin
            logic [3:0] e0, e7;
            wr_start[1] = (c == 0);
            wr_start[2] = (c == 0);
            @(negedge sys_clk);
            e0 = {(c >= 1 && c <= 6), (c >= 2 && c <= 5), (c >= 2 && c <= 7), (c >= 3 && c <= 6)};
            e7 = {(c >= 1 && c <= 13), (c >= 9 && c <= 12), (c >= 9 && c <= 14), (c >= 10 && c <= 13)};
            chk($sformatf("lat0_c%0d", c), {60'b0, busy[1], wready[1], dqs_oe[1], dq_oe[1]}, {60'b0, e0});
            chk($sformatf("lat7_c%0d", c), {60'b0, busy[2], wready[2], dqs_oe[2], dq_oe[2]}, {60'b0, e7});
            @(posedge sys_clk);
            #1;
        end
        wr_start[1] = 1'b0;
        wr_start[2] = 1'b0;
        wvalid      = 1'b0;

        // Async reset while beat 2 is on the pins, with a wr_start held across the reset edge.
        for (int i = 0; i < 6; i++) run_row(i);
        drive(6);
        @(negedge sys_clk);
        chk("rst_pre_row6", {20'b0, act}, {20'b0, tbl[6].exp});
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_async_pins", {60'b0, busy[0], wready[0], dq_oe[0], dqs_oe[0]}, 64'h0);
        chk("rst_async_all", {20'b0, act}, 64'h0);
        wr_start[0] = 1'b1;
        wvalid      = 1'b0;
        @(posedge sys_clk);
        #1;
        wr_start[0] = 1'b0;
        sys_rst_n   = 1'b1;
        @(negedge sys_clk);
        chk("rst_start_dropped", {20'b0, act}, 64'h0);
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 10; i++) run_row(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
